// File: rtl/cpu_mem_pkg.sv
// Shared constants and address decode for the data-side memory map
// (RAM words, MMIO register offsets, STATUS bit positions).
package cpu_mem_pkg;

  localparam logic [15:0] MMIO_BASE = 16'hFFF0;

  localparam logic [2:0] OFS_TX     = 3'd0;
  localparam logic [2:0] OFS_STATUS = 3'd1;
  localparam logic [2:0] OFS_TLD    = 3'd2;
  localparam logic [2:0] OFS_TCT    = 3'd3;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_EXPIRED = 3;

  typedef enum logic [2:0] {
    RGN_NONE,
    RGN_RAM,
    RGN_TX,
    RGN_STATUS,
    RGN_TLD,
    RGN_TCT
  } region_e;

  // The MMIO window is assumed 8-word aligned; +4..+7 fall through to RGN_NONE.
  function automatic region_e decode_addr(input logic [15:0] addr,
                                          input logic [15:0] base,
                                          input int          ram_aw);
    region_e r;
    r = RGN_NONE;
    if ((addr >> ram_aw) == 16'd0) begin
      r = RGN_RAM;
    end else if (addr[15:3] == base[15:3]) begin
      case (addr[2:0])
        OFS_TX:     r = RGN_TX;
        OFS_STATUS: r = RGN_STATUS;
        OFS_TLD:    r = RGN_TLD;
        OFS_TCT:    r = RGN_TCT;
        default:    r = RGN_NONE;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/data_ram_mmio_if.sv
// CPU data-port and tx-stream signal bundle for data_ram_mmio.
interface data_ram_mmio_if;

  logic [15:0] data_ram_addr;
  logic        data_ram_wen;
  logic [15:0] data_ram_wdata;
  logic [15:0] data_ram_rdata;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic        tx_ready;
  logic        timer_irq;

  modport slave (
    input  data_ram_addr, data_ram_wen, data_ram_wdata, tx_ready,
    output data_ram_rdata, tx_valid, tx_data, timer_irq
  );

  modport master (
    output data_ram_addr, data_ram_wen, data_ram_wdata, tx_ready,
    input  data_ram_rdata, tx_valid, tx_data, timer_irq
  );

endinterface

// File: rtl/sync_fifo_16.sv
// 16-bit synchronous FIFO, depth 2**AW, no fall-through; head reads 0 when empty.
module sync_fifo_16 #(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != FULL_CNT) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = empty ? 16'h0000 : mem_q[rd_ptr_q];

endmodule

// File: rtl/data_ram_mmio.sv
// Data-side RAM plus MMIO window (tx FIFO, STATUS, down-counting timer).
// Timer logic is present only when DATA_RAM_MMIO_TIMER_EN is defined.
module data_ram_mmio #(
  parameter int          RAM_AW    = 12,
  parameter int          FIFO_AW   = 3,
  parameter logic [15:0] MMIO_BASE = cpu_mem_pkg::MMIO_BASE
) (
  input  logic           clk,
  input  logic           rst,
  data_ram_mmio_if.slave bus
);

  import cpu_mem_pkg::*;

  localparam int RAM_DEPTH = 2 ** RAM_AW;
  localparam int CW        = FIFO_AW + 1;

  region_e       region;
  logic [15:0]   ram_q [RAM_DEPTH];
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [15:0]   fifo_head;
  logic          tx_push;
  logic          status_wr;
  logic          ovf_q, ovf_d;
  logic          expired;
  logic [15:0]   tld_rd, tct_rd;
  logic [15:0]   status_rd;

  assign region    = decode_addr(bus.data_ram_addr, MMIO_BASE, RAM_AW);
  assign tx_push   = bus.data_ram_wen && (region == RGN_TX);
  assign status_wr = bus.data_ram_wen && (region == RGN_STATUS);

  // RAM contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (bus.data_ram_wen && (region == RGN_RAM))
      ram_q[bus.data_ram_addr[RAM_AW-1:0]] <= bus.data_ram_wdata;
  end

  sync_fifo_16 #(.AW(FIFO_AW)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (bus.tx_ready),
    .wdata (bus.data_ram_wdata),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.tx_valid = !fifo_empty;
  assign bus.tx_data  = fifo_head;

  // Sticky set is evaluated after the W1C so a same-cycle set wins.
  always_comb begin
    ovf_d = ovf_q;
    if (status_wr && bus.data_ram_wdata[ST_OVF]) ovf_d = 1'b0;
    if (tx_push && fifo_full && !bus.tx_ready)   ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

`ifdef DATA_RAM_MMIO_TIMER_EN
  logic [15:0] tld_q, tld_d;
  logic [15:0] tct_q, tct_d;
  logic        exp_q, exp_d;
  logic        tld_wr;

  assign tld_wr = bus.data_ram_wen && (region == RGN_TLD);

  // A load overrides the decrement, and loading 0 parks the timer without expiring.
  always_comb begin
    tld_d = tld_q;
    tct_d = tct_q;
    exp_d = exp_q;
    if (status_wr && bus.data_ram_wdata[ST_EXPIRED]) exp_d = 1'b0;
    if (tld_wr) begin
      tld_d = bus.data_ram_wdata;
      tct_d = bus.data_ram_wdata;
    end else if (tct_q != 16'd0) begin
      tct_d = tct_q - 16'd1;
      if (tct_q == 16'd1) exp_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tld_q <= '0;
      tct_q <= '0;
      exp_q <= 1'b0;
    end else begin
      tld_q <= tld_d;
      tct_q <= tct_d;
      exp_q <= exp_d;
    end
  end

  assign tld_rd  = tld_q;
  assign tct_rd  = tct_q;
  assign expired = exp_q;
`else
  assign tld_rd  = 16'h0000;
  assign tct_rd  = 16'h0000;
  assign expired = 1'b0;
`endif

  assign bus.timer_irq = expired;

  always_comb begin
    status_rd             = '0;
    status_rd[ST_FULL]    = fifo_full;
    status_rd[ST_EMPTY]   = fifo_empty;
    status_rd[ST_OVF]     = ovf_q;
    status_rd[ST_EXPIRED] = expired;
  end

  always_comb begin
    bus.data_ram_rdata = 16'h0000;
    case (region)
      RGN_RAM:    bus.data_ram_rdata = ram_q[bus.data_ram_addr[RAM_AW-1:0]];
      RGN_TX:     bus.data_ram_rdata = {{(16-CW){1'b0}}, fifo_count};
      RGN_STATUS: bus.data_ram_rdata = status_rd;
      RGN_TLD:    bus.data_ram_rdata = tld_rd;
      RGN_TCT:    bus.data_ram_rdata = tct_rd;
      default:    bus.data_ram_rdata = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_data_ram_mmio.sv
// Scoreboard bench for data_ram_mmio: register reads checked inline, tx stream
// checked by a negedge monitor against a queue of expected words.
module tb_data_ram_mmio;

  localparam logic [15:0] A_TX     = 16'hFFF0;
  localparam logic [15:0] A_STATUS = 16'hFFF1;
  localparam logic [15:0] A_TLD    = 16'hFFF2;
  localparam logic [15:0] A_TCT    = 16'hFFF3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_ram_mmio_if bus();

  data_ram_mmio dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] sb [$];
  logic        irq_seen = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [15:0] exp_w;
    if (!rst && bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL tx_unexpected: got %h expected no word", bus.tx_data);
      end else begin
        exp_w = sb.pop_front();
        if (bus.tx_data !== exp_w) begin
          n_err++;
          $display("FAIL tx_word: got %h expected %h", bus.tx_data, exp_w);
        end
      end
    end
    if (bus.timer_irq === 1'b1) irq_seen = 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    bus.data_ram_addr  = a;
    bus.data_ram_wdata = d;
    bus.data_ram_wen   = 1'b1;
    @(posedge clk);
    #1;
    bus.data_ram_wen   = 1'b0;
  endtask

  task automatic rd(input string name, input logic [15:0] a, input logic [15:0] e);
    bus.data_ram_addr = a;
    bus.data_ram_wen  = 1'b0;
    @(negedge clk);
    chk(name, bus.data_ram_rdata, e);
  endtask

  task automatic push(input logic [15:0] d, input bit expect_out);
    if (expect_out) sb.push_back(d);
    wr(A_TX, d);
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    sync();
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 40 && sb.size() != 0; i++) sync();
    bus.tx_ready = 1'b0;
    chk("drain_done", 16'(sb.size()), 16'd0);
  endtask

  initial begin
    bus.data_ram_addr  = 16'h0000;
    bus.data_ram_wen   = 1'b0;
    bus.data_ram_wdata = 16'h0000;
    bus.tx_ready       = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_valid", {15'b0, bus.tx_valid}, 16'd0);
    chk("rst_tx_data", bus.tx_data, 16'h0000);
    chk("rst_irq", {15'b0, bus.timer_irq}, 16'd0);
    rst = 1'b0;
    rd("rst_status", A_STATUS, 16'h0002);
    rd("rst_count", A_TX, 16'h0000);

    // RAM and unmapped space
    wr(16'h0005, 16'h1234);
    rd("ram_5", 16'h0005, 16'h1234);
    wr(16'h0006, 16'hCAFE);
    rd("ram_6", 16'h0006, 16'hCAFE);
    rd("ram_5_again", 16'h0005, 16'h1234);
    wr(16'h0000, 16'h1111);
    wr(16'h0FFF, 16'h2222);
    wr(16'h1000, 16'h7777);
    rd("ram_0_no_alias", 16'h0000, 16'h1111);
    rd("ram_top", 16'h0FFF, 16'h2222);
    rd("unmapped_1000", 16'h1000, 16'h0000);
    wr(16'h2000, 16'hBEEF);
    rd("unmapped_2000", 16'h2000, 16'h0000);
    wr(16'hFFF5, 16'h5555);
    rd("mmio_hole", 16'hFFF5, 16'h0000);

    // Overflow: nine pushes into eight slots
    sync();
    for (int i = 0; i < 9; i++) push(16'hA000 + 16'(i), i < 8);
    rd("full_status", A_STATUS, 16'h0005);
    rd("full_count", A_TX, 16'h0008);
    drain();
    rd("drained_status", A_STATUS, 16'h0006);
    wr(A_STATUS, 16'h0004);
    rd("ovf_cleared", A_STATUS, 16'h0002);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) push(16'hB000 + 16'(i), 1'b1);
    rd("refill_count", A_TX, 16'h0008);
    sync();
    bus.tx_ready = 1'b1;
    sb.push_back(16'hBEEF);
    wr(A_TX, 16'hBEEF);
    bus.tx_ready = 1'b0;
    rd("pushpop_count", A_TX, 16'h0008);
    rd("pushpop_status", A_STATUS, 16'h0001);
    push(16'hDEAD, 1'b0);
    rd("ovf_again", A_STATUS, 16'h0005);
    wr(A_STATUS, 16'h0004);
    rd("ovf_w1c", A_STATUS, 16'h0001);
    drain();
    rd("empty_status", A_STATUS, 16'h0002);

    // Empty FIFO with push and ready: no fall-through
    sync();
    bus.tx_ready       = 1'b1;
    sb.push_back(16'hC0DE);
    bus.data_ram_addr  = A_TX;
    bus.data_ram_wdata = 16'hC0DE;
    bus.data_ram_wen   = 1'b1;
    @(negedge clk);
    chk("no_fallthrough", {15'b0, bus.tx_valid}, 16'd0);
    @(posedge clk);
    #1;
    bus.data_ram_wen = 1'b0;
    drain();

    // Reset in the middle of a queued stream
    for (int i = 0; i < 5; i++) push(16'hD000 + 16'(i), 1'b0);
    rd("five_count", A_TX, 16'h0005);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_tx_valid", {15'b0, bus.tx_valid}, 16'd0);
    chk("midrst_tx_data", bus.tx_data, 16'h0000);
    rd("midrst_count", A_TX, 16'h0000);
    sync();
    rst = 1'b0;
    rd("ram_kept_5", 16'h0005, 16'h1234);
    rd("ram_kept_6", 16'h0006, 16'hCAFE);
    rd("post_rst_status", A_STATUS, 16'h0002);

`ifdef DATA_RAM_MMIO_TIMER_EN
    wr(A_TLD, 16'd3);
    for (int i = 0; i < 4; i++) begin
      rd("tct_countdown", A_TCT, 16'(3 - i));
      chk("irq_countdown", {15'b0, bus.timer_irq}, (i == 3) ? 16'd1 : 16'd0);
    end
    rd("expired_status", A_STATUS, 16'h000A);
    rd("tld_readback", A_TLD, 16'd3);
    wr(A_STATUS, 16'h0008);
    rd("expired_w1c", A_STATUS, 16'h0002);
    chk("irq_cleared", {15'b0, bus.timer_irq}, 16'd0);
    wr(A_TLD, 16'd2);
    rd("tct_2", A_TCT, 16'd2);
    rd("tct_1", A_TCT, 16'd1);
    wr(A_TLD, 16'd5);
    rd("load_wins", A_TCT, 16'd5);
    chk("load_wins_irq", {15'b0, bus.timer_irq}, 16'd0);
    wr(A_TLD, 16'd0);
    rd("load0_tct", A_TCT, 16'd0);
    rd("load0_status", A_STATUS, 16'h0002);
    wr(A_TLD, 16'd1);
    wr(A_STATUS, 16'h0008);
    rd("set_beats_w1c", A_STATUS, 16'h000A);
    chk("set_beats_w1c_irq", {15'b0, bus.timer_irq}, 16'd1);
    wr(A_STATUS, 16'h0008);
    rd("final_w1c", A_STATUS, 16'h0002);
`else
    wr(A_TLD, 16'd5);
    rd("notimer_tld", A_TLD, 16'h0000);
    rd("notimer_tct", A_TCT, 16'h0000);
    rd("notimer_status", A_STATUS, 16'h0002);
    repeat (10) @(posedge clk);
    #1;
    chk("notimer_irq", {15'b0, irq_seen}, 16'd0);
`endif

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
